// File: rtl/gnn_pkg.sv
// Shared definitions for the GNN output datapath.
//   OUTPUT_SIZE   - width of one result word
//   NUM_NODES     - graph nodes per frame
//   OUTS_PER_NODE - result words per node
//   FRAME_WORDS   - words per frame (node-major, output-minor order)
//   PTR_W         - width of a word index inside a frame
//   state_t       - serializer FSM states
package gnn_pkg;

  localparam int OUTPUT_SIZE   = 21;
  localparam int NUM_NODES     = 4;
  localparam int OUTS_PER_NODE = 2;
  localparam int FRAME_WORDS   = NUM_NODES * OUTS_PER_NODE;
  localparam int PTR_W         = 3;

  typedef enum logic {
    IDLE,
    STREAM
  } state_t;

endpackage

// File: rtl/gnn_next_idx.sv
// Combinational priority finder over a frame's nonzero mask.
// Returns the lowest set mask bit above 'start' (or at 'start' when
// 'inclusive' is high). 'last' is high when no such bit exists, so it doubles
// as "the word at start is the final one" when searching exclusively.
// Ports:
//   mask      in  FRAME_WORDS  nonzero flags of the captured frame
//   start     in  PTR_W        search origin
//   inclusive in  1            also consider the bit at start
//   idx       out PTR_W        index of the found bit (0 when none)
//   last      out 1            no qualifying bit was found
module gnn_next_idx
  import gnn_pkg::*;
(
  input  logic [FRAME_WORDS-1:0] mask,
  input  logic [PTR_W-1:0]       start,
  input  logic                   inclusive,
  output logic [PTR_W-1:0]       idx,
  output logic                   last
);

  // Scan downward so the lowest qualifying bit is the one left standing.
  always_comb begin
    idx  = '0;
    last = 1'b1;
    for (int i = FRAME_WORDS - 1; i >= 0; i--) begin
      if (mask[i] && ((i > int'(start)) || (inclusive && (i == int'(start))))) begin
        idx  = i[PTR_W-1:0];
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/gnn_out_serializer.sv
// Output serializer for the GNN datapath. Captures the eight node results on
// the rising edge of "all outputs ready" and streams them one word per
// valid/ready transfer, node0/out0 first through node3/out1 last. Frames that
// arrive while a stream is in progress are dropped and flagged via overrun.
// Optional build macro GNN_OUT_SKIP_ZERO_EN: zero-valued words are skipped
// and an all-zero frame produces only a frame_done pulse.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in0_node*, in1_node*     per-node results (raw OUTPUT_SIZE bits)
//   rdy0_node*, rdy1_node*   per-output ready flags
//   dout/dout_node/dout_idx/dout_last, dout_valid, dout_ready  stream port
//   busy                     frame held or streaming
//   frame_done               one-cycle pulse after a frame completes
//   overrun                  sticky dropped-frame flag
module gnn_out_serializer
  import gnn_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  input  logic [OUTPUT_SIZE-1:0] in0_node0,
  input  logic [OUTPUT_SIZE-1:0] in0_node1,
  input  logic [OUTPUT_SIZE-1:0] in0_node2,
  input  logic [OUTPUT_SIZE-1:0] in0_node3,
  input  logic [OUTPUT_SIZE-1:0] in1_node0,
  input  logic [OUTPUT_SIZE-1:0] in1_node1,
  input  logic [OUTPUT_SIZE-1:0] in1_node2,
  input  logic [OUTPUT_SIZE-1:0] in1_node3,
  input  logic                   rdy0_node0,
  input  logic                   rdy0_node1,
  input  logic                   rdy0_node2,
  input  logic                   rdy0_node3,
  input  logic                   rdy1_node0,
  input  logic                   rdy1_node1,
  input  logic                   rdy1_node2,
  input  logic                   rdy1_node3,
  output logic [OUTPUT_SIZE-1:0] dout,
  output logic                   dout_valid,
  input  logic                   dout_ready,
  output logic [1:0]             dout_node,
  output logic                   dout_idx,
  output logic                   dout_last,
  output logic                   busy,
  output logic                   frame_done,
  output logic                   overrun
);

  logic [OUTPUT_SIZE-1:0] new_words [FRAME_WORDS];
  logic [OUTPUT_SIZE-1:0] frame_buf [FRAME_WORDS];
  logic                   all_rdy, all_rdy_q, frame_event;
  state_t                 state, state_next;
  logic [PTR_W-1:0]       ptr, ptr_next, ptr_succ;
  logic                   last_word, capture, done_next;
  logic                   stream_start;
  logic [PTR_W-1:0]       start_ptr;

  // Flatten the input bus into stream order: index = 2*node + output.
  always_comb begin
    new_words[0] = in0_node0;
    new_words[1] = in1_node0;
    new_words[2] = in0_node1;
    new_words[3] = in1_node1;
    new_words[4] = in0_node2;
    new_words[5] = in1_node2;
    new_words[6] = in0_node3;
    new_words[7] = in1_node3;
  end

  assign all_rdy = rdy0_node0 & rdy0_node1 & rdy0_node2 & rdy0_node3 &
                   rdy1_node0 & rdy1_node1 & rdy1_node2 & rdy1_node3;

  // Only the rising edge counts, so a ready level held high captures once.
  assign frame_event = all_rdy & ~all_rdy_q;

`ifdef GNN_OUT_SKIP_ZERO_EN
  logic [FRAME_WORDS-1:0] new_mask, mask;
  logic                   first_none;

  always_comb begin
    for (int i = 0; i < FRAME_WORDS; i++) begin
      new_mask[i] = |new_words[i];
    end
  end

  gnn_next_idx u_first (
    .mask      (new_mask),
    .start     ({PTR_W{1'b0}}),
    .inclusive (1'b1),
    .idx       (start_ptr),
    .last      (first_none)
  );

  // Exclusive search from ptr: the found bit is the successor, and finding
  // none means the word now presented is the last nonzero one.
  gnn_next_idx u_succ (
    .mask      (mask),
    .start     (ptr),
    .inclusive (1'b0),
    .idx       (ptr_succ),
    .last      (last_word)
  );

  assign stream_start = ~first_none;

  always_ff @(posedge clk) begin
    if (rst) begin
      mask <= '0;
    end else if (capture) begin
      mask <= new_mask;
    end
  end
`else
  assign start_ptr    = '0;
  assign stream_start = 1'b1;
  assign ptr_succ     = ptr + PTR_W'(1);
  assign last_word    = (ptr == PTR_W'(FRAME_WORDS - 1));
`endif

  // Next-state logic. A capture that finds nothing to send (skip-zero build
  // only) completes immediately without entering STREAM.
  always_comb begin
    state_next = state;
    ptr_next   = ptr;
    capture    = 1'b0;
    done_next  = 1'b0;
    case (state)
      IDLE: begin
        if (frame_event) begin
          capture = 1'b1;
          if (stream_start) begin
            state_next = STREAM;
            ptr_next   = start_ptr;
          end else begin
            done_next = 1'b1;
          end
        end
      end
      STREAM: begin
        if (dout_ready) begin
          if (last_word) begin
            state_next = IDLE;
            ptr_next   = '0;
            done_next  = 1'b1;
          end else begin
            ptr_next = ptr_succ;
          end
        end
      end
      default: begin
        state_next = IDLE;
        ptr_next   = '0;
      end
    endcase
  end

  // Overrun also catches an event coinciding with the final transfer, since
  // the FSM is still in STREAM during that cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      ptr        <= '0;
      all_rdy_q  <= 1'b0;
      frame_done <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      state      <= state_next;
      ptr        <= ptr_next;
      all_rdy_q  <= all_rdy;
      frame_done <= done_next;
      if (frame_event && (state == STREAM)) begin
        overrun <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      frame_buf <= new_words;
    end
  end

  assign busy       = (state == STREAM);
  assign dout_valid = busy;
  assign dout       = busy ? frame_buf[ptr] : '0;
  assign dout_node  = busy ? ptr[2:1] : 2'd0;
  assign dout_idx   = busy & ptr[0];
  assign dout_last  = busy & last_word;

endmodule

// File: doc/gnn_out_serializer.md
Name: gnn_out_serializer

Overview:
Reader at the output end of the GNN datapath. It collects the eight 21-bit node outputs (out0/out1 for nodes 0-3) once all eight ready flags are high. It then streams them one word per transfer over a valid/ready interface to the host or readout logic. This turns the wide parallel result bus into a narrow stream and flags result frames that are lost while a stream is still in progress.

Parameters:
- OUTPUT_SIZE, 21, width of each result word.
- NUM_NODES, 4, number of graph nodes; the node index field is 2 bits.
- OUTS_PER_NODE, 2, outputs per node; frame length = NUM_NODES*OUTS_PER_NODE = 8.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- in0_node0..in0_node3  in  OUTPUT_SIZE each  output-0 result of each node (signed).
- in1_node0..in1_node3  in  OUTPUT_SIZE each  output-1 result of each node (signed).
- rdy0_node0..rdy0_node3, rdy1_node0..rdy1_node3  in  1 each  per-output ready flags from the GNN.
- dout  out  OUTPUT_SIZE  current stream word.
- dout_valid  out  1  dout, dout_node, dout_idx and dout_last are valid.
- dout_ready  in  1  consumer accepts the word.
- dout_node  out  2  node index of the current word.
- dout_idx  out  1  output index (0/1) within the node.
- dout_last  out  1  current word is the final word of the frame.
- busy  out  1  a frame is held or streaming.
- frame_done  out  1  one-cycle pulse after the frame completes.
- overrun  out  1  sticky; a frame arrived while busy and was dropped.

Behaviour:
- all_rdy = AND of the eight rdy flags. all_rdy_q is a registered copy. A frame event is all_rdy & ~all_rdy_q (rising edge); a level held high captures only once.
- FSM has two states: IDLE and STREAM.
- IDLE:
  - On a frame event, register all eight inputs into an 8-entry buffer, set ptr=0 and go to STREAM.
  - dout_valid is 1 from the next cycle, so capture-to-first-valid latency is 1 cycle.
- STREAM:
  - dout = buf[ptr]. Order is node0/out0, node0/out1, node1/out0, ... node3/out1.
  - dout_node = ptr[2:1], dout_idx = ptr[0].
  - A transfer is dout_valid & dout_ready. On a transfer ptr increments.
  - dout_last is asserted when ptr = 7. A transfer with dout_last set returns the FSM to IDLE and pulses frame_done in the next cycle.
  - While dout_ready is low, dout and its sideband fields stay stable and dout_valid stays high. Valid is never withdrawn without a transfer.
- A frame event in STREAM is dropped and sets overrun. This includes the cycle of the last transfer, because the FSM is still in STREAM that cycle. overrun clears only on rst.
- busy = (state == STREAM).
- Buffer entries are held as raw OUTPUT_SIZE-bit values; there is no arithmetic, sign extension or truncation.
- Reset values: state=IDLE, ptr=0, dout=0, dout_valid=0, dout_node=0, dout_idx=0, dout_last=0, busy=0, frame_done=0, overrun=0, all_rdy_q=0.
- Reset mid-stream aborts the frame at once; no partial frame_done is issued.
- If reset releases with all_rdy already high, the first cycle counts as a frame event (all_rdy_q=0).

Optional Feature:
- Macro: GNN_OUT_SKIP_ZERO_EN.
- With the macro:
  - An 8-bit nonzero mask is captured with the frame. Entries equal to zero, for example ReLU-clipped outputs, are skipped.
  - ptr jumps to the next set mask bit, and dout_node/dout_idx report the true position.
  - dout_last marks the highest set bit.
  - An all-zero frame emits no words: the FSM stays in IDLE and frame_done pulses the cycle after capture.
- Without the macro: all eight words are always emitted and no mask logic is present.

Decomposition:
- Shared package gnn_pkg:
  - OUTPUT_SIZE, NUM_NODES and OUTS_PER_NODE constants.
  - FRAME_WORDS = 8.
  - The state enum {IDLE, STREAM}.
- One natural sub-module: gnn_next_idx, a combinational priority finder that returns the next set mask bit above ptr, plus a last flag. It is instantiated only under GNN_OUT_SKIP_ZERO_EN.

Test Plan:
- Basic frame, dout_ready tied 1: in0_node0=1, in1_node0=2 ... in1_node3=8, all rdy raised at cycle 5.
  - Expect dout_valid at cycle 6 and dout = 1..8 on cycles 6-13.
  - dout_last only at cycle 13; frame_done at cycle 14.
- Backpressure: dout_ready low for 3 cycles while word 3 (node1/out1, value 4) is presented.
  - Expect dout=4, dout_node=1, dout_idx=1 stable with valid high, then continue with 5.
- Overrun: drop the rdy flags and re-raise them during word 2.
  - Expect overrun=1 and the stream to continue with the original values.
  - No second frame after the last word.
- Level hold: rdy held high for 30 cycles with dout_ready=1.
  - Expect exactly one frame (8 transfers) and overrun=0.
- Reset mid-stream: assert rst after the 4th transfer.
  - Expect next cycle dout_valid=0, busy=0, no frame_done.
  - A new frame event then streams from word 0.
- GNN_OUT_SKIP_ZERO_EN: values {0, 7, 0, 0, -3, 0, 0, 0}.
  - Expect two transfers: 7 (node0, idx1), then -3 (node2, idx0) with dout_last.
  - An all-zero frame gives no valid words and a single frame_done pulse.
